// File: rtl/dice_roller.sv
// Six-die roller: edge-detected roll/hold/new_turn, LFSR-driven tumble, registered outputs.
// Optional three-roll limit with a DONE state is enabled by defining DICE_ROLL_LIMIT_EN.
module dice_roller #(
    parameter int          ROLL_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        roll,
    input  logic [5:0]  hold_btn,
    input  logic        new_turn,
    output logic [23:0] r,
    output logic [5:0]  s,
    output logic        a,
    output logic [5:0]  held,
    output logic [1:0]  rolls_left,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, TUMBLE, SHOW, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] r_q, r_d;
    logic [5:0]  s_q, s_d;
    logic [5:0]  held_q, held_d;
    logic [1:0]  rl_q, rl_d;
    logic        a_q, a_d;
    logic        busy_q, busy_d;
    logic        roll_q, nt_q;
    logic [5:0]  hold_q;
    logic        armed_q;

    logic        roll_ev, nt_ev;
    logic [5:0]  hold_ev;

    function automatic logic [3:0] next_face(input logic [3:0] v);
        return (v == 4'd6) ? 4'd1 : v + 4'd1;
    endfunction

    // armed_q delays edge detection so a level already high at reset release never fires
    assign roll_ev = armed_q & roll & ~roll_q;
    assign nt_ev   = armed_q & new_turn & ~nt_q;
    assign hold_ev = {6{armed_q}} & hold_btn & ~hold_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        s_d     = s_q;
        held_d  = held_q;
        rl_d    = rl_q;
        case (state_q)
            IDLE: begin
                if (roll_ev && rl_q != 2'd0) begin
                    state_d = TUMBLE;
                    cnt_d   = 8'(ROLL_CYCLES - 1);
                    s_d     = s_q | ~held_q;
                end
            end
            TUMBLE: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                for (int i = 0; i < 6; i++) begin
                    if (!held_q[i] && lfsr_q[i])
                        r_d[4*i +: 4] = next_face(r_q[4*i +: 4]);
                end
                if (cnt_q == 8'd0) begin
`ifdef DICE_ROLL_LIMIT_EN
                    rl_d    = rl_q - 2'd1;
                    state_d = (rl_d == 2'd0) ? DONE : SHOW;
`else
                    state_d = SHOW;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SHOW: begin
                // holds land first so the tumble that may start now sees the new mask
                held_d = held_q ^ hold_ev;
                if (roll_ev && rl_q != 2'd0) begin
                    state_d = TUMBLE;
                    cnt_d   = 8'(ROLL_CYCLES - 1);
                    s_d     = s_q | ~held_d;
                end
            end
            default: ;
        endcase
        if (nt_ev) begin
            state_d = IDLE;
            held_d  = 6'd0;
            s_d     = 6'd0;
            rl_d    = 2'd3;
            cnt_d   = 8'd0;
            r_d     = r_q;
        end
        a_d    = (state_d != IDLE);
        busy_d = (state_d == TUMBLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= 8'd0;
            r_q     <= 24'h111111;
            s_q     <= 6'd0;
            held_q  <= 6'd0;
            rl_q    <= 2'd3;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            roll_q  <= 1'b0;
            nt_q    <= 1'b0;
            hold_q  <= 6'd0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            s_q     <= s_d;
            held_q  <= held_d;
            rl_q    <= rl_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            roll_q  <= roll;
            nt_q    <= new_turn;
            hold_q  <= hold_btn;
            armed_q <= 1'b1;
        end
    end

    assign r          = r_q;
    assign s          = s_q;
    assign a          = a_q;
    assign held       = held_q;
    assign rolls_left = rl_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: vector table of turn events, reference dice/LFSR model feeding an r scoreboard.
module tb_dice_roller;

    localparam int          RC   = 16;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef DICE_ROLL_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        roll = 1'b0;
    logic [5:0]  hold_btn = 6'd0;
    logic        new_turn = 1'b0;
    logic [23:0] r;
    logic [5:0]  s;
    logic        a;
    logic [5:0]  held;
    logic [1:0]  rolls_left;
    logic        busy;

    int checks = 0;
    int failures = 0;

    dice_roller #(.ROLL_CYCLES(RC), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .roll(roll), .hold_btn(hold_btn), .new_turn(new_turn),
        .r(r), .s(s), .a(a), .held(held), .rolls_left(rolls_left), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       roll;
        logic [5:0] hold;
        logic       nt;
        int         exp_busy;
        logic [5:0] exp_held;
        logic [5:0] exp_s;
        logic [1:0] exp_rl;
        logic       exp_a;
    } vec_t;

    vec_t        vt[13];
    logic [15:0] m_lfsr;
    logic [23:0] m_r;
    logic [23:0] r_q[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [3:0] face_up(input logic [3:0] v);
        return (v >= 4'd6) ? 4'd1 : v + 4'd1;
    endfunction

    task automatic model_tumble(input logic [5:0] hm);
        logic fb;
        for (int c = 0; c < RC; c++) begin
            for (int i = 0; i < 6; i++)
                if (!hm[i] && m_lfsr[i]) m_r[4*i +: 4] = face_up(m_r[4*i +: 4]);
            fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
            m_lfsr = {m_lfsr[14:0], fb};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_lfsr = SEED;
        m_r    = 24'h111111;
        r_q.delete();
    endtask

    task automatic pulse(input logic rl, input logic [5:0] hb, input logic nt);
        @(posedge clk);
        #1;
        roll = rl; hold_btn = hb; new_turn = nt;
        @(posedge clk);
        #1;
        roll = 1'b0; hold_btn = 6'd0; new_turn = 1'b0;
    endtask

    // no die ever shows a value outside 1..6 while out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            logic bad;
            bad = 1'b0;
            for (int i = 0; i < 6; i++)
                if (r[4*i +: 4] == 4'd0 || r[4*i +: 4] > 4'd6) bad = 1'b1;
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL die_range got=%06h expected all nibbles 1..6", r);
            end
        end
    end

    initial begin
        int          nb;
        logic        hbad;
        logic [23:0] snap, mask, er;

        // roll held high through reset release must not count as an edge
        roll = 1'b1;
        do_reset();
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("rst_level_roll_busy", 0, nb, 0);
        chk("rst_r", 0, r, 24'h111111);
        chk("rst_s", 0, s, 0);
        chk("rst_a", 0, a, 0);
        chk("rst_held", 0, held, 0);
        chk("rst_rl", 0, rolls_left, 3);
        chk("rst_busy", 0, busy, 0);
        roll = 1'b0;
        repeat (2) @(posedge clk);

        //          roll  hold   nt  busy           held    s      rl                  a
        vt[0]  = '{1'b0, 6'h01, 1'b0, 0,             6'h00, 6'h00, 2'd3,              1'b0};
        vt[1]  = '{1'b1, 6'h00, 1'b0, RC,            6'h00, 6'h3F, LIM ? 2'd2 : 2'd3, 1'b1};
        vt[2]  = '{1'b0, 6'h09, 1'b0, 0,             6'h09, 6'h3F, LIM ? 2'd2 : 2'd3, 1'b1};
        vt[3]  = '{1'b1, 6'h00, 1'b0, RC,            6'h09, 6'h3F, LIM ? 2'd1 : 2'd3, 1'b1};
        vt[4]  = '{1'b1, 6'h02, 1'b0, RC,            6'h0B, 6'h3F, LIM ? 2'd0 : 2'd3, 1'b1};
        vt[5]  = '{1'b1, 6'h00, 1'b0, LIM ? 0 : RC,  6'h0B, 6'h3F, LIM ? 2'd0 : 2'd3, 1'b1};
        vt[6]  = '{1'b0, 6'h01, 1'b0, 0,             LIM ? 6'h0B : 6'h0A, 6'h3F, LIM ? 2'd0 : 2'd3, 1'b1};
        vt[7]  = '{1'b0, 6'h00, 1'b1, 0,             6'h00, 6'h00, 2'd3,              1'b0};
        vt[8]  = '{1'b1, 6'h00, 1'b1, 0,             6'h00, 6'h00, 2'd3,              1'b0};
        vt[9]  = '{1'b1, 6'h00, 1'b0, RC,            6'h00, 6'h3F, LIM ? 2'd2 : 2'd3, 1'b1};
        vt[10] = '{1'b0, 6'h3F, 1'b0, 0,             6'h3F, 6'h3F, LIM ? 2'd2 : 2'd3, 1'b1};
        vt[11] = '{1'b1, 6'h00, 1'b0, RC,            6'h3F, 6'h3F, LIM ? 2'd1 : 2'd3, 1'b1};
        vt[12] = '{1'b0, 6'h00, 1'b1, 0,             6'h00, 6'h00, 2'd3,              1'b0};

        for (int k = 0; k < 13; k++) begin
            if (vt[k].exp_busy > 0) model_tumble(vt[k].exp_held);
            r_q.push_back(m_r);
            mask = 24'hFFFFFF;
            if (vt[k].exp_busy > 0)
                for (int i = 0; i < 6; i++) mask[4*i +: 4] = {4{vt[k].exp_held[i]}};
            snap = r;
            pulse(vt[k].roll, vt[k].hold, vt[k].nt);
            nb = 0;
            hbad = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (busy) nb++;
                if (((r ^ snap) & mask) != 24'd0) hbad = 1'b1;
            end
            chk("busy_cycles", k, nb, vt[k].exp_busy);
            chk("held_dice_stable", k, hbad, 0);
            chk("held", k, held, vt[k].exp_held);
            chk("s", k, s, vt[k].exp_s);
            chk("rolls_left", k, rolls_left, vt[k].exp_rl);
            chk("a", k, a, vt[k].exp_a);
            chk("busy_after", k, busy, 0);
            if (r_q.size() == 0) begin
                chk("scoreboard_empty", k, 1, 0);
            end else begin
                er = r_q.pop_front();
                chk("r", k, r, er);
            end
        end

        // new_turn lands on the fifth tumble edge
        do_reset();
        repeat (2) @(posedge clk);
        pulse(1'b1, 6'h00, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 0, busy, 1);
        #1;
        new_turn = 1'b1;
        @(posedge clk);
        #1 new_turn = 1'b0;
        @(negedge clk);
        chk("abort_busy", 0, busy, 0);
        chk("abort_s", 0, s, 0);
        chk("abort_a", 0, a, 0);
        chk("abort_held", 0, held, 0);
        chk("abort_rl", 0, rolls_left, 3);
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", 0, busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
